// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared types and constants for the snake game score path.
//   score_state_t     : score keeper game state (IDLE / PLAYING / OVER)
//   SCORE_MAX_DEFAULT : default saturation value of the score
//   BCD_DIGITS        : number of BCD digits carried beside the binary score
//   bcd_t             : packed BCD digit vector, digit 0 = ones
//   to_bcd()          : constant-friendly binary to BCD conversion
// ---------------------------------------------------------------------------
package snake_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAYING,
      S_OVER
   } score_state_t;

   localparam int SCORE_MAX_DEFAULT = 999;
   localparam int BCD_DIGITS        = 3;

   typedef logic [BCD_DIGITS-1:0][3:0] bcd_t;

   // Only ever evaluated on parameters, so the divisions fold away at
   // elaboration and never reach the netlist.
   function automatic bcd_t to_bcd(int value);
      bcd_t digits;
      int   rest;
      rest = value;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         digits[i] = 4'(rest % 10);
         rest      = rest / 10;
      end
      return digits;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// One decimal digit of a ripple BCD adder.
//   digit     in  4  current BCD digit (0..9)
//   addend    in  4  value added to the digit (0..9)
//   carry_in  in  1  carry from the next-lower digit
//   digit_out out 4  resulting BCD digit (0..9)
//   carry_out out 1  carry into the next-higher digit
// Inputs must satisfy digit + addend + carry_in <= 19.
// ---------------------------------------------------------------------------
module bcd_digit_add (
   input  logic [3:0] digit,
   input  logic [3:0] addend,
   input  logic       carry_in,
   output logic [3:0] digit_out,
   output logic       carry_out
);

   logic [4:0] sum;

   assign sum       = {1'b0, digit} + {1'b0, addend} + {4'b0000, carry_in};
   assign carry_out = (sum >= 5'd10);
   // For sums 10..19, subtracting 10 modulo 16 on the low nibble gives the
   // same result as a full 5-bit subtraction, so no wide adjust is needed.
   assign digit_out = carry_out ? (sum[3:0] - 4'd10) : sum[3:0];

endmodule

// File: rtl/snake_score_keeper.sv
// ---------------------------------------------------------------------------
// snake_score_keeper
// Game score producer for the VGA score display. Counts food events while
// playing, saturates at MAX_SCORE, holds the score after game over and keeps
// the session high score. A BCD copy of the score is kept in lockstep so the
// display needs no dividers.
//   clk        in   1        system clock
//   reset      in   1        synchronous, active-high reset
//   new_game   in   1        level; start or restart a game
//   food_eaten in   1        one event per rising edge
//   game_over  in   1        level; ends the current game
//   score      out  SCORE_W  current binary score
//   ones       out  4        BCD ones digit of score
//   tens       out  4        BCD tens digit of score
//   huns       out  4        BCD hundreds digit of score
//   high_score out  SCORE_W  best score since reset
//   playing    out  1        high while in PLAYING
//   new_high   out  1        high in OVER when the last game set a new high
// All outputs are registered.
// ---------------------------------------------------------------------------
module snake_score_keeper
   import snake_pkg::*;
#(
   parameter int MAX_SCORE       = SCORE_MAX_DEFAULT,
   parameter int POINTS_PER_FOOD = 1,
   parameter int SCORE_W         = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               new_game,
   input  logic               food_eaten,
   input  logic               game_over,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         ones,
   output logic [3:0]         tens,
   output logic [3:0]         huns,
   output logic [SCORE_W-1:0] high_score,
   output logic               playing,
   output logic               new_high
);

   localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W+1)'(MAX_SCORE);
   localparam logic [SCORE_W:0] PTS_EXT = (SCORE_W+1)'(POINTS_PER_FOOD);
   localparam bcd_t             MAX_BCD = to_bcd(MAX_SCORE);

   score_state_t       state_q, state_d;
   logic               food_prev_q;
   logic               food_evt;
   bcd_t               digits_q, digits_d, digits_sum, digits_inc;
   logic [BCD_DIGITS:0] carry;
   logic [SCORE_W:0]   score_sum;
   logic               saturate;
   logic [SCORE_W-1:0] score_inc, score_after, score_d, high_d;
   logic               new_high_d;
   bcd_t               digits_after;

   assign food_evt = food_eaten & ~food_prev_q;

   // ---- increment path: binary and BCD computed side by side ----
   assign score_sum = {1'b0, score} + PTS_EXT;
   assign carry[0]  = 1'b0;

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
      bcd_digit_add u_add (
         .digit     (digits_q[g]),
         .addend    ((g == 0) ? 4'(POINTS_PER_FOOD) : 4'd0),
         .carry_in  (carry[g]),
         .digit_out (digits_sum[g]),
         .carry_out (carry[g+1])
      );
   end

   // A carry out of the top digit can only happen past MAX_SCORE, so it is
   // folded into the saturation test rather than left dangling.
   assign saturate   = (score_sum > MAX_EXT) || carry[BCD_DIGITS];
   assign score_inc  = saturate ? MAX_EXT[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
   assign digits_inc = saturate ? MAX_BCD : digits_sum;

   // Food is counted before any game_over decision in the same cycle.
   assign score_after  = food_evt ? score_inc  : score;
   assign digits_after = food_evt ? digits_inc : digits_q;

   // ---- state register ----
   // NOTE: synchronous reset lives inside the clocked block, and all state
   // uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---- next-state logic ----
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (new_game)  state_d = S_PLAYING;
         S_PLAYING: if (game_over) state_d = S_OVER;
         S_OVER:    if (new_game)  state_d = S_PLAYING;
         default:   state_d = S_IDLE;
      endcase
   end

   // ---- output / datapath next values ----
   // NOTE: every signal gets a hold default first so no path leaves one
   // unassigned and infers a latch.
   always_comb begin
      score_d    = score;
      digits_d   = digits_q;
      high_d     = high_score;
      new_high_d = new_high;
      unique case (state_q)
         S_IDLE: begin
            score_d    = '0;
            digits_d   = '0;
            new_high_d = 1'b0;
         end
         S_PLAYING: begin
            if (game_over) begin
               score_d    = score_after;
               digits_d   = digits_after;
               new_high_d = (score_after > high_score);
               if (score_after > high_score) high_d = score_after;
            end else if (new_game) begin
               score_d  = '0;
               digits_d = '0;
            end else begin
               score_d  = score_after;
               digits_d = digits_after;
            end
         end
         S_OVER: begin
            if (new_game) begin
               score_d    = '0;
               digits_d   = '0;
               new_high_d = 1'b0;
            end
         end
         default: begin
            score_d    = '0;
            digits_d   = '0;
            new_high_d = 1'b0;
         end
      endcase
   end

   // ---- output registers ----
   always_ff @(posedge clk) begin
      if (reset) begin
         food_prev_q <= 1'b0;
         score       <= '0;
         digits_q    <= '0;
         high_score  <= '0;
         playing     <= 1'b0;
         new_high    <= 1'b0;
      end else begin
         food_prev_q <= food_eaten;
         score       <= score_d;
         digits_q    <= digits_d;
         high_score  <= high_d;
         playing     <= (state_d == S_PLAYING);
         new_high    <= new_high_d;
      end
   end

   assign ones = digits_q[0];
   assign tens = digits_q[1];
   assign huns = digits_q[2];

endmodule

// File: tb/tb_snake_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_snake_score_keeper
// Two score keepers (1 and 5 points per food) share one stimulus stream.
// A game-level model predicts every output each cycle; literal expectations
// at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_snake_score_keeper;

   localparam int SW = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic new_game = 1'b0;
   logic food_eaten = 1'b0;
   logic game_over = 1'b0;

   logic [SW-1:0] score1, high1, score5, high5;
   logic [3:0]    ones1, tens1, huns1, ones5, tens5, huns5;
   logic          playing1, new_high1, playing5, new_high5;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   snake_score_keeper #(.POINTS_PER_FOOD(1)) dut1 (
      .clk(clk), .reset(reset), .new_game(new_game), .food_eaten(food_eaten),
      .game_over(game_over), .score(score1), .ones(ones1), .tens(tens1),
      .huns(huns1), .high_score(high1), .playing(playing1), .new_high(new_high1)
   );

   snake_score_keeper #(.POINTS_PER_FOOD(5)) dut5 (
      .clk(clk), .reset(reset), .new_game(new_game), .food_eaten(food_eaten),
      .game_over(game_over), .score(score5), .ones(ones5), .tens(tens5),
      .huns(huns5), .high_score(high5), .playing(playing5), .new_high(new_high5)
   );

   // ---- game-level model ----
   typedef enum int {M_IDLE, M_PLAY, M_OVER} mode_t;
   typedef struct {
      mode_t mode;
      int    score;
      int    high;
      bit    new_high;
      bit    food_prev;
   } model_t;

   model_t m1, m5;
   bit     model_valid = 1'b0;

   function automatic model_t model_next(model_t m, bit rst, bit ng, bit food,
                                         bit go, int pts);
      model_t n;
      bit     evt;
      n = m;
      if (rst) begin
         n.mode = M_IDLE; n.score = 0; n.high = 0;
         n.new_high = 1'b0; n.food_prev = 1'b0;
         return n;
      end
      evt         = food && !m.food_prev;
      n.food_prev = food;
      case (m.mode)
         M_IDLE: if (ng) n.mode = M_PLAY;
         M_PLAY: begin
            if (evt) n.score = (m.score + pts > 999) ? 999 : m.score + pts;
            if (go) begin
               n.mode     = M_OVER;
               n.new_high = (n.score > m.high);
               if (n.score > m.high) n.high = n.score;
            end else if (ng) begin
               n.score = 0;
            end
         end
         M_OVER: if (ng) begin
            n.mode = M_PLAY; n.score = 0; n.new_high = 1'b0;
         end
         default: n.mode = M_IDLE;
      endcase
      return n;
   endfunction

   always @(posedge clk) begin
      m1 = model_next(m1, reset, new_game, food_eaten, game_over, 1);
      m5 = model_next(m5, reset, new_game, food_eaten, game_over, 5);
      if (reset) model_valid = 1'b1;
   end

   task automatic check(string name, int actual, int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic cmp_outputs(string tag, model_t m, int sc, int o, int t, int h,
                              int hs, int pl, int nh);
      check({tag, "_score"},    sc, m.score);
      check({tag, "_ones"},     o,  m.score % 10);
      check({tag, "_tens"},     t,  (m.score / 10) % 10);
      check({tag, "_huns"},     h,  m.score / 100);
      check({tag, "_high"},     hs, m.high);
      check({tag, "_playing"},  pl, (m.mode == M_PLAY) ? 1 : 0);
      check({tag, "_new_high"}, nh, m.new_high ? 1 : 0);
   endtask

   // Compare every cycle, half a period away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         cmp_outputs("cyc_p1", m1, int'(score1), int'(ones1), int'(tens1), int'(huns1),
                     int'(high1), int'(playing1), int'(new_high1));
         cmp_outputs("cyc_p5", m5, int'(score5), int'(ones5), int'(tens5), int'(huns5),
                     int'(high5), int'(playing5), int'(new_high5));
      end
   end

   // ---- stimulus helpers ----
   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_food(int n = 1);
      repeat (n) begin
         food_eaten = 1'b1; step();
         food_eaten = 1'b0; step();
      end
   endtask

   task automatic pulse_new_game();
      new_game = 1'b1; step();
      new_game = 1'b0;
   endtask

   task automatic pulse_game_over();
      game_over = 1'b1; step();
      game_over = 1'b0;
   endtask

   initial begin
      step(2);
      reset = 1'b0;
      check("rst_score", int'(score1), 0);
      check("rst_high", int'(high1), 0);
      check("rst_playing", int'(playing1), 0);
      check("rst_new_high", int'(new_high1), 0);

      // IDLE ignores food
      pulse_food(2);
      check("idle_food_ignored", int'(score1), 0);

      // Game 1: 12 pulses, held-high food, end at 37
      pulse_new_game();
      check("start_playing", int'(playing1), 1);
      pulse_food(12);
      check("g1_score12", int'(score1), 12);
      check("g1_ones", int'(ones1), 2);
      check("g1_tens", int'(tens1), 1);
      check("g1_huns", int'(huns1), 0);
      check("g1_p5_score60", int'(score5), 60);
      food_eaten = 1'b1; step(20);
      food_eaten = 1'b0; step();
      check("held_food_once", int'(score1), 13);
      pulse_food(24);
      pulse_game_over();
      check("g1_over_high", int'(high1), 37);
      check("g1_over_new_high", int'(new_high1), 1);
      check("g1_over_playing", int'(playing1), 0);
      check("g1_p5_high", int'(high5), 185);
      pulse_food(2);
      check("over_holds_score", int'(score1), 37);

      // Game 2 ends at 20, below the high score
      pulse_new_game();
      check("g2_cleared", int'(score1), 0);
      pulse_food(20);
      pulse_game_over();
      check("g2_score_held", int'(score1), 20);
      check("g2_high_kept", int'(high1), 37);
      check("g2_new_high", int'(new_high1), 0);
      pulse_new_game();
      check("g3_cleared", int'(score1), 0);
      check("g3_new_high", int'(new_high1), 0);

      // Food edge and game_over in the same cycle at 41
      pulse_food(41);
      check("g3_score41", int'(score1), 41);
      food_eaten = 1'b1; game_over = 1'b1; step();
      food_eaten = 1'b0; game_over = 1'b0;
      check("simul_score", int'(score1), 42);
      check("simul_high", int'(high1), 42);
      check("simul_playing", int'(playing1), 0);
      check("simul_p5_high", int'(high5), 210);

      // game_over + new_game together: game_over wins
      pulse_new_game();
      new_game = 1'b1; game_over = 1'b1; step();
      new_game = 1'b0; game_over = 1'b0;
      check("go_ng_over", int'(playing1), 0);
      step();
      check("go_ng_stays_over", int'(playing1), 0);
      new_game = 1'b1; step();
      check("ng_held_enters", int'(playing1), 1);
      step(3);
      check("ng_held_stays", int'(playing1), 1);
      new_game = 1'b0;

      // Reach high 80, then reset mid-game at 55
      pulse_food(80);
      pulse_game_over();
      pulse_new_game();
      pulse_food(55);
      check("pre_reset_score", int'(score1), 55);
      check("pre_reset_high", int'(high1), 80);
      reset = 1'b1; step();
      reset = 1'b0;
      check("mid_reset_score", int'(score1), 0);
      check("mid_reset_high", int'(high1), 0);
      check("mid_reset_playing", int'(playing1), 0);
      pulse_food(3);
      check("post_reset_food_ignored", int'(score1), 0);

      // Saturation runs for both point values
      pulse_new_game();
      for (int i = 1; i <= 998; i++) begin
         pulse_food(1);
         if (i == 199) check("p5_score995", int'(score5), 995);
         if (i == 200) check("p5_sat999", int'(score5), 999);
         if (i == 201) check("p5_stays999", int'(score5), 999);
      end
      check("p1_score998", int'(score1), 998);
      check("p1_998_huns", int'(huns1), 9);
      check("p1_998_ones", int'(ones1), 8);
      for (int i = 0; i < 3; i++) begin
         pulse_food(1);
         check("p1_sat999", int'(score1), 999);
         check("p1_sat_ones", int'(ones1), 9);
         check("p1_sat_tens", int'(tens1), 9);
         check("p1_sat_huns", int'(huns1), 9);
      end

      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
